// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic, shift-add multiply and restoring
// divide (one bit per cycle), with the result and flags held on a valid/ready output.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             parity,
    output logic             overflow,
    output logic             div_zero
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_PAS = 3'd7;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        even_parity = ~^v;
    endfunction

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [2:0]       op_r, op_s;
    logic [WIDTH-1:0] div_r, div_s;
    logic [WIDTH-1:0] hi_r, hi_s, lo_r, lo_s;
    logic [WIDTH:0]   add_s, sub_s, mul_sum_s, div_trial_s;
    logic [WIDTH-1:0] hi_iter_s, lo_iter_s;
    logic             load_s, carry_s, ovf_s, dz_s;
    logic [WIDTH-1:0] res_s, res_hi_s;

    logic [WIDTH-1:0] result_r, result_hi_r;
    logic             zero_r, carry_r, sign_r, parity_r, overflow_r, div_zero_r;
    logic             out_valid_r, in_ready_r;

    // Datapath arithmetic: single-cycle sums and one multiply/divide iteration
    always_comb begin
        add_s       = {1'b0, a} + {1'b0, b};
        sub_s       = {1'b0, a} - {1'b0, b};
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, div_r} : {(WIDTH+1){1'b0}});
        div_trial_s = {hi_r, lo_r[MSB]} - {1'b0, div_r};
        if (op_r == OP_MUL) begin
            {hi_iter_s, lo_iter_s} = {mul_sum_s, lo_r[MSB:1]};
        end else if (!div_trial_s[WIDTH]) begin
            hi_iter_s = div_trial_s[WIDTH-1:0];
            lo_iter_s = {lo_r[MSB-1:0], 1'b1};
        end else begin
            // trial went negative: restore by keeping the shifted remainder
            hi_iter_s = {hi_r[MSB-1:0], lo_r[MSB]};
            lo_iter_s = {lo_r[MSB-1:0], 1'b0};
        end
    end

    // Next-state logic and the values loaded into the output registers
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        op_s     = op_r;
        div_s    = div_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        load_s   = 1'b0;
        res_s    = '0;
        res_hi_s = '0;
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        dz_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    op_s    = op;
                    div_s   = b;
                    load_s  = 1'b1;
                    state_s = DONE;
                    case (op)
                        OP_ADD: begin
                            res_s   = add_s[WIDTH-1:0];
                            carry_s = add_s[WIDTH];
                            ovf_s   = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
                        end
                        OP_SUB: begin
                            res_s   = sub_s[WIDTH-1:0];
                            carry_s = sub_s[WIDTH];
                            ovf_s   = (a[MSB] != b[MSB]) && (sub_s[MSB] != a[MSB]);
                        end
                        OP_MUL, OP_DIV: begin
                            if (b == '0) begin
                                res_s    = (op == OP_DIV) ? '1 : '0;
                                res_hi_s = (op == OP_DIV) ? a : '0;
                                dz_s     = (op == OP_DIV);
                            end else begin
                                load_s  = 1'b0;
                                state_s = BUSY;
                                cnt_s   = '0;
                                hi_s    = '0;
                                lo_s    = a;
                            end
                        end
                        OP_AND:  res_s = a & b;
                        OP_OR:   res_s = a | b;
                        OP_XOR:  res_s = a ^ b;
                        OP_PAS:  res_s = a;
                        default: res_s = a;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                hi_s = hi_iter_s;
                lo_s = lo_iter_s;
                if (cnt_r == LAST) begin
                    cnt_s    = '0;
                    load_s   = 1'b1;
                    res_s    = lo_iter_s;
                    res_hi_s = hi_iter_s;
                    carry_s  = (op_r == OP_MUL) && (hi_iter_s != '0);
                    state_s  = DONE;
                end else begin
                    cnt_s = cnt_r + ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Control and iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            op_r    <= 3'd0;
            div_r   <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            div_r   <= div_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
        end
    end

    // Output registers: handshake follows the next state, data loads on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            result_r    <= '0;
            result_hi_r <= '0;
            zero_r      <= 1'b1;
            carry_r     <= 1'b0;
            sign_r      <= 1'b0;
            parity_r    <= 1'b0;
            overflow_r  <= 1'b0;
            div_zero_r  <= 1'b0;
        end else begin
            out_valid_r <= (state_s == DONE);
            in_ready_r  <= (state_s == IDLE);
            if (load_s) begin
                result_r    <= res_s;
                result_hi_r <= res_hi_s;
                zero_r      <= ~|res_s;
                carry_r     <= carry_s;
                sign_r      <= res_s[MSB];
                parity_r    <= even_parity(res_s);
                overflow_r  <= ovf_s;
                div_zero_r  <= dz_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign zero      = zero_r;
    assign carry     = carry_r;
    assign sign      = sign_r;
    assign parity    = parity_r;
    assign overflow  = overflow_r;
    assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=8: expected results are queued when an
// operation is driven and compared when the DUT presents out_valid.
module tb_alu_mc;

    localparam int W = 8;

    typedef struct packed {
        logic [21:0] outs;
        logic [7:0]  lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] result, result_hi;
    logic         zero, carry, sign, parity, overflow, div_zero;
    logic [21:0]  obs;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
        .sign(sign), .parity(parity), .overflow(overflow), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    assign obs = {result, result_hi, zero, carry, sign, parity, overflow, div_zero};

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [8:0]  t9;
        logic [15:0] p16;
        logic [7:0]  r, h;
        logic        c, v, d;
        r = 8'h00; h = 8'h00; c = 1'b0; v = 1'b0; d = 1'b0;
        case (o)
            3'd0: begin t9 = {1'b0, x} + {1'b0, y}; r = t9[7:0]; c = t9[8];
                        v = (x[7] == y[7]) && (r[7] != x[7]); end
            3'd1: begin r = x - y; c = (x < y); v = (x[7] != y[7]) && (r[7] != x[7]); end
            3'd2: begin p16 = {8'h00, x} * {8'h00, y}; r = p16[7:0]; h = p16[15:8]; c = (h != 8'h00); end
            3'd3: begin
                if (y == 8'h00) begin r = 8'hFF; h = x; d = 1'b1; end
                else begin r = x / y; h = x % y; end
            end
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = x ^ y;
            default: r = x;
        endcase
        model.outs = {r, h, (r == 8'h00), c, r[7], ~^r, v, d};
        model.lat  = ((o == 3'd2 || o == 3'd3) && y != 8'h00) ? 8'd9 : 8'd1;
    endfunction

    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        sb.push_back(model(o, x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output bit rdy_seen);
        lat = 1; rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== {8'h00, 8'h00, 6'b100000}) begin
            miscompares++;
            $display("FAIL reset: rdy=%b vld=%b outs=%h, want rdy=1 vld=0 outs=%h",
                     in_ready, out_valid, obs, {8'h00, 8'h00, 6'b100000});
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_table;
        logic [2:0] ops [17] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                                 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [7:0] as [17]  = '{8'hFF, 8'h7F, 8'h80, 8'h05, 8'h80, 8'h33, 8'hFF, 8'h12, 8'h5A,
                                 8'd200, 8'h05, 8'hFF, 8'h03, 8'hF0, 8'hF0, 8'hAA, 8'h81};
        logic [7:0] bs [17]  = '{8'h01, 8'h01, 8'h80, 8'h07, 8'h01, 8'h33, 8'hFF, 8'h34, 8'h00,
                                 8'd7, 8'h00, 8'h01, 8'd200, 8'h3C, 8'h0C, 8'hFF, 8'h00};
        exp_t e;
        int   lat;
        bit   rdy;
        for (int i = 0; i < 17; i++) begin
            send(ops[i], as[i], bs[i]);
            wait_result(lat, rdy);
            e = sb.pop_front();
            vectors++;
            if (out_valid !== 1'b1 || obs !== e.outs) begin
                miscompares++;
                $display("FAIL table op=%0d a=%h b=%h: got vld=%b outs=%h, want outs=%h",
                         ops[i], as[i], bs[i], out_valid, obs, e.outs);
            end
            vectors++;
            if (lat != int'(e.lat)) begin
                miscompares++;
                $display("FAIL latency op=%0d a=%h b=%h: got %0d, want %0d",
                         ops[i], as[i], bs[i], lat, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_mul_busy;
        exp_t e;
        int   lat;
        bit   rdy;
        send(3'd2, 8'hFF, 8'hFF);
        wait_result(lat, rdy);
        e = sb.pop_front();
        vectors++;
        if (rdy !== 1'b0 || lat != 9 || result !== 8'h01 || result_hi !== 8'hFE || carry !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_busy: rdy_in_busy=%b lat=%0d res=%h hi=%h c=%b, want 0 9 01 FE 1",
                     rdy, lat, result, result_hi, carry);
        end
        vectors++;
        if (obs !== e.outs) begin
            miscompares++;
            $display("FAIL mul_busy_outs: got %h, want %h", obs, e.outs);
        end
        consume();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   lat;
        bit   rdy;
        send(3'd1, 8'h05, 8'h07);
        wait_result(lat, rdy);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 3'd0; a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== e.outs) begin
                miscompares++;
                $display("FAIL backpressure cyc=%0d: vld=%b rdy=%b outs=%h, want 1 0 %h",
                         i, out_valid, in_ready, obs, e.outs);
            end
        end
        consume();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ignored: vld=%b, want 0", out_valid);
        end
    endtask

    task automatic test_idle_ready;
        @(negedge clk) out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_ready cyc=%0d: vld=%b rdy=%b, want 0 1", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   lat;
        bit   rdy;
        @(negedge clk);
        op = 3'd2; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || zero !== 1'b1 || result !== 8'h00 || result_hi !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: vld=%b rdy=%b z=%b res=%h hi=%h, want 0 1 1 00 00",
                     out_valid, in_ready, zero, result, result_hi);
        end
        @(negedge clk) rst_n = 1'b1;
        send(3'd0, 8'd3, 8'd4);
        wait_result(lat, rdy);
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || lat != 1 || result !== 8'd7 || obs !== e.outs) begin
            miscompares++;
            $display("FAIL after_reset_add: vld=%b lat=%0d outs=%h, want 1 1 %h",
                     out_valid, lat, obs, e.outs);
        end
        consume();
    endtask

    task automatic test_back_to_back;
        exp_t       e;
        int         lat;
        bit         rdy;
        logic [2:0] o;
        logic [7:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = 8'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            send(o, x, y);
            wait_result(lat, rdy);
            e = sb.pop_front();
            vectors++;
            if (out_valid !== 1'b1 || obs !== e.outs || lat != int'(e.lat)) begin
                miscompares++;
                $display("FAIL b2b op=%0d a=%h b=%h: vld=%b outs=%h lat=%0d, want %h lat=%0d",
                         o, x, y, out_valid, obs, lat, e.outs, e.lat);
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_table();
        test_mul_busy();
        test_backpressure();
        test_idle_ready();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the datapath. Operands and opcode arrive on a valid/ready input channel. Add, subtract and logic ops complete in one cycle. Multiply (shift-add) and divide (restoring) iterate one bit per cycle. Each result, with its full flag set, is held on a valid/ready output channel until it is consumed.

## Interface
- Clock `clk`, single clock domain; reset `rst_n`, asynchronous, active-low.
- `WIDTH`, default 8: operand and result width; legal range 4..32.
- `clk` in, 1: clock, rising edge.
- `rst_n` in, 1: asynchronous active-low reset.
- `in_valid` in, 1: operand/opcode valid.
- `in_ready` out, 1: block can accept an operation.
- `op` in, 3: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 pass A.
- `a`, `b` in, WIDTH each: unsigned operands; signed view is used only for `overflow`.
- `out_valid` out, 1: result and flags valid.
- `out_ready` in, 1: consumer takes the result.
- `result` out, WIDTH: sum, difference, product low half, quotient, or logic result.
- `result_hi` out, WIDTH: product high half or division remainder; 0 for all other ops.
- `zero`, `carry`, `sign`, `parity`, `overflow`, `div_zero` out, 1 each: status flags.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- `in_ready` = (state == IDLE).
- Accept happens on a rising edge with `in_valid & in_ready`; `op`, `a`, `b` are captured.
- Accept of ops 0, 1, 4–7: the result is computed and registered on the accepting edge; IDLE→DONE.
- Accept of op 2 or 3 with `b != 0`: IDLE→BUSY; iteration counter loaded with 0.
- Op 2 or 3 with `b == 0`: see the division rules below; IDLE→DONE.
- BUSY performs one iteration per edge. After iteration WIDTH (counter == WIDTH-1), BUSY→DONE.
- DONE holds `out_valid = 1` and all outputs stable. On an edge with `out_ready = 1`, DONE→IDLE.
- No new operation is accepted in BUSY or DONE. Inputs in those states are ignored.
- Arithmetic rules:
  - add: {carry, result} = a + b (WIDTH+1 bits).
  - sub: result = a - b mod 2^WIDTH; carry = borrow = (a < b).
  - mul: {result_hi, result} = a * b (2·WIDTH bits); carry = (result_hi != 0).
  - div: result = a / b, result_hi = a % b; carry = 0.
  - Division by zero: result = all ones, result_hi = a, div_zero = 1, completes with latency 1 (no iteration). div_zero = 0 for every other case.
  - Op 2 with b == 0 completes in 1 cycle with product 0.
  - Logic ops and pass: carry = 0, result_hi = 0.
- Flags always describe `result`:
  - zero = ~|result.
  - sign = result[WIDTH-1].
  - parity = ~^result (1 when the count of ones is even).
  - overflow: add = (a[MSB] == b[MSB]) & (result[MSB] != a[MSB]); sub = (a[MSB] != b[MSB]) & (result[MSB] != a[MSB]); 0 for all other ops.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `result`/`result_hi` 0, all flags 0 except `zero` = 1 (consistent with result 0), counter 0.
- Latency is counted as edges from the accepting edge (inclusive) to `out_valid` high:
  - ops 0, 1, 4–7 and div/mul by zero: 1.
  - mul and div: WIDTH+1.
- Throughput: at most one operation per 2 cycles, because DONE→IDLE consumes an edge.
- Backpressure: `out_valid` stays high and outputs stay frozen for any number of cycles while `out_ready` = 0.
- `out_ready` asserted while not in DONE has no effect.
- `rst_n` low at any time, including mid-iteration in BUSY, immediately forces reset values. The in-flight operation is discarded; no partial result is emitted.
- `rst_n` deassertion is synchronised by the integrator. The first accept can occur on the first edge with `rst_n` high.

## Test plan
- WIDTH=8, add a=0xFF, b=0x01 → after 1 edge: result 0x00, carry 1, zero 1, parity 1, overflow 0; add 0x7F+0x01 → 0x80, overflow 1, sign 1.
- Sub a=0x05, b=0x07 → result 0xFE, carry 1, sign 1; sub 0x80-0x01 → 0x7F, overflow 1.
- Mul a=0xFF, b=0xFF → out_valid exactly 9 edges after accept; result 0x01, result_hi 0xFE, carry 1; in_ready 0 throughout BUSY.
- Div a=200, b=7 → result 28, result_hi 4 after 9 edges; div a=5, b=0 → 1 edge, result 0xFF, result_hi 5, div_zero 1.
- Hold out_ready=0 for 5 cycles in DONE → outputs unchanged, in_valid pulses ignored; out_ready=1 → IDLE next edge, in_ready 1.
- Assert rst_n=0 during the 4th mul iteration → out_valid 0, in_ready 1, zero 1 immediately. A subsequent add 3+4 returns 7 normally.
